// File: rtl/or_sweep_checker.sv
// Built-in self-test sweeper for a W-bit OR array: drives every (a, b) pair below all-ones,
// compares the returned z against a|b after LATENCY cycles, and counts and records mismatches.
module or_sweep_checker #(
    parameter int MSB          = 7,
    parameter int LATENCY      = 0,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [MSB:0] a,
    output logic [MSB:0] b,
    input  logic [MSB:0] z,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [15:0]  err_count,
    output logic [MSB:0] fail_a,
    output logic [MSB:0] fail_b,
    output logic [MSB:0] fail_z
);

    localparam logic [MSB:0] LAST = {{MSB{1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t       state_q, state_d;
    logic [MSB:0] a_q, a_d, b_q, b_d;
    logic [15:0]  err_q, err_d;
    logic [MSB:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d, fail_z_q, fail_z_d;
    logic [1:0]   drain_q, drain_d;
    logic         busy_q, busy_d, done_q, done_d, pass_q, pass_d;

    logic         chk_v;
    logic [MSB:0] chk_a, chk_b;
    logic         mismatch, abort;

    // The vector being judged this edge: the live one, or the one LATENCY cycles old.
    generate
        if (LATENCY == 0) begin : g_nopipe
            assign chk_v = (state_q == RUN);
            assign chk_a = a_q;
            assign chk_b = b_q;
        end else begin : g_pipe
            logic [LATENCY-1:0] pv_q, pv_d;
            logic [MSB:0]       pa_q [LATENCY];
            logic [MSB:0]       pa_d [LATENCY];
            logic [MSB:0]       pb_q [LATENCY];
            logic [MSB:0]       pb_d [LATENCY];

            always_comb begin
                pv_d = pv_q;
                pa_d = pa_q;
                pb_d = pb_q;
                for (int i = LATENCY - 1; i > 0; i--) begin
                    pv_d[i] = pv_q[i-1];
                    pa_d[i] = pa_q[i-1];
                    pb_d[i] = pb_q[i-1];
                end
                pv_d[0] = (state_q == RUN);
                pa_d[0] = a_q;
                pb_d[0] = b_q;
                if (abort) pv_d = '0;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pv_q <= '0;
                    for (int i = 0; i < LATENCY; i++) begin
                        pa_q[i] <= '0;
                        pb_q[i] <= '0;
                    end
                end else begin
                    pv_q <= pv_d;
                    pa_q <= pa_d;
                    pb_q <= pb_d;
                end
            end

            assign chk_v = pv_q[LATENCY-1];
            assign chk_a = pa_q[LATENCY-1];
            assign chk_b = pb_q[LATENCY-1];
        end
    endgenerate

    // Case inequality so that X/Z on the returned bus counts as a failure.
    assign mismatch = chk_v && (z !== (chk_a | chk_b));
    assign abort    = mismatch && (STOP_ON_FAIL != 0);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        err_d    = err_q;
        fail_a_d = fail_a_q;
        fail_b_d = fail_b_q;
        fail_z_d = fail_z_q;
        drain_d  = drain_q;

        if (mismatch) begin
            err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
            if (err_q == 16'd0) begin
                fail_a_d = chk_a;
                fail_b_d = chk_b;
                fail_z_d = z;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    a_d      = '0;
                    b_d      = '0;
                    err_d    = '0;
                    fail_a_d = '0;
                    fail_b_d = '0;
                    fail_z_d = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = DONE;
                end else if (a_q == LAST && b_q == LAST) begin
                    state_d = (LATENCY > 0) ? DRAIN : DONE;
                    drain_d = 2'(LATENCY - 1);
                end else if (b_q == LAST) begin
                    b_d = '0;
                    a_d = a_q + 1'b1;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            DRAIN: begin
                if (abort || drain_q == 2'd0) state_d = DONE;
                else                          drain_d = drain_q - 2'd1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == 16'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            err_q    <= '0;
            fail_a_q <= '0;
            fail_b_q <= '0;
            fail_z_q <= '0;
            drain_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            err_q    <= err_d;
            fail_a_q <= fail_a_d;
            fail_b_q <= fail_b_d;
            fail_z_q <= fail_z_d;
            drain_q  <= drain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;
    assign fail_z    = fail_z_q;

endmodule

// File: tb/tb_or_sweep_checker.sv
// Directed bench: three 8-bit checkers (good array, stuck-at bit 3 with and without abort)
// share one start; two 2-bit checkers face a twice-registered OR array.
module tb_or_sweep_checker;

    logic clk = 1'b0;
    logic rst, start8, start2;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    logic [7:0]  a_c, b_c, z_c, fa_c, fb_c, fz_c;
    logic        busy_c, done_c, pass_c;
    logic [15:0] err_c;
    logic [7:0]  a_s, b_s, z_s, fa_s, fb_s, fz_s;
    logic        busy_s, done_s, pass_s;
    logic [15:0] err_s;
    logic [7:0]  a_f, b_f, z_f, fa_f, fb_f, fz_f;
    logic        busy_f, done_f, pass_f;
    logic [15:0] err_f;
    logic [1:0]  a_l, b_l, z_l, fa_l, fb_l, fz_l;
    logic        busy_l, done_l, pass_l;
    logic [15:0] err_l;
    logic [1:0]  a_n, b_n, z_n, fa_n, fb_n, fz_n;
    logic        busy_n, done_n, pass_n;
    logic [15:0] err_n;
    logic [1:0]  l_r1, l_r2, n_r1, n_r2;

    assign z_c = a_c | b_c;
    assign z_s = (a_s | b_s) & 8'hF7;
    assign z_f = (a_f | b_f) & 8'hF7;

    always @(posedge clk) begin
        l_r1 <= a_l | b_l;
        l_r2 <= l_r1;
        n_r1 <= a_n | b_n;
        n_r2 <= n_r1;
    end
    assign z_l = l_r2;
    assign z_n = n_r2;

    or_sweep_checker #(.MSB(7), .LATENCY(0), .STOP_ON_FAIL(1)) u_clean (
        .clk(clk), .rst(rst), .start(start8), .a(a_c), .b(b_c), .z(z_c), .busy(busy_c),
        .done(done_c), .pass(pass_c), .err_count(err_c), .fail_a(fa_c), .fail_b(fb_c), .fail_z(fz_c));
    or_sweep_checker #(.MSB(7), .LATENCY(0), .STOP_ON_FAIL(1)) u_stuck_abort (
        .clk(clk), .rst(rst), .start(start8), .a(a_s), .b(b_s), .z(z_s), .busy(busy_s),
        .done(done_s), .pass(pass_s), .err_count(err_s), .fail_a(fa_s), .fail_b(fb_s), .fail_z(fz_s));
    or_sweep_checker #(.MSB(7), .LATENCY(0), .STOP_ON_FAIL(0)) u_stuck_full (
        .clk(clk), .rst(rst), .start(start8), .a(a_f), .b(b_f), .z(z_f), .busy(busy_f),
        .done(done_f), .pass(pass_f), .err_count(err_f), .fail_a(fa_f), .fail_b(fb_f), .fail_z(fz_f));
    or_sweep_checker #(.MSB(1), .LATENCY(2), .STOP_ON_FAIL(1)) u_lat2 (
        .clk(clk), .rst(rst), .start(start2), .a(a_l), .b(b_l), .z(z_l), .busy(busy_l),
        .done(done_l), .pass(pass_l), .err_count(err_l), .fail_a(fa_l), .fail_b(fb_l), .fail_z(fz_l));
    or_sweep_checker #(.MSB(1), .LATENCY(0), .STOP_ON_FAIL(0)) u_lat0 (
        .clk(clk), .rst(rst), .start(start2), .a(a_n), .b(b_n), .z(z_n), .busy(busy_n),
        .done(done_n), .pass(pass_n), .err_count(err_n), .fail_a(fa_n), .fail_b(fb_n), .fail_z(fz_n));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset values, then an asynchronous mid-cycle reset that wipes a partly-failed sweep.
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        total++; if (busy_c !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%0h want=0", busy_c); end
        total++; if (done_c !== 1'b0) begin bad++; $display("[TB] FAIL rst_done got=%0h want=0", done_c); end
        total++; if (pass_c !== 1'b0) begin bad++; $display("[TB] FAIL rst_pass got=%0h want=0", pass_c); end
        total++; if (err_c !== 16'h0) begin bad++; $display("[TB] FAIL rst_err got=%0h want=0", err_c); end
        total++; if ({a_c, b_c} !== 16'h0) begin bad++; $display("[TB] FAIL rst_ab got=%0h want=0", {a_c, b_c}); end
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (12) tick();
        total++; if (err_f !== 16'd4) begin bad++; $display("[TB] FAIL pre_rst_err got=%0d want=4", err_f); end
        total++; if (done_s !== 1'b1) begin bad++; $display("[TB] FAIL pre_rst_done got=%0h want=1", done_s); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (err_f !== 16'h0) begin bad++; $display("[TB] FAIL async_err got=%0d want=0", err_f); end
        total++; if (fb_f !== 8'h0) begin bad++; $display("[TB] FAIL async_failb got=%0h want=0", fb_f); end
        total++; if (busy_f !== 1'b0) begin bad++; $display("[TB] FAIL async_busy got=%0h want=0", busy_f); end
        total++; if ({a_f, b_f} !== 16'h0) begin bad++; $display("[TB] FAIL async_ab got=%0h want=0", {a_f, b_f}); end
        total++; if (done_s !== 1'b0) begin bad++; $display("[TB] FAIL async_done got=%0h want=0", done_s); end
        start8 = 1'b1;
        tick();
        total++; if (busy_c !== 1'b0) begin bad++; $display("[TB] FAIL start_in_rst got=%0h want=0", busy_c); end
        start8 = 1'b0;
        rst = 1'b0;
        tick();
        total++; if (busy_c !== 1'b0) begin bad++; $display("[TB] FAIL need_start got=%0h want=0", busy_c); end
    endtask

    // Twice-registered array: LATENCY=2 passes, LATENCY=0 sees stale results on 5 of 9 vectors.
    task automatic test_latency();
        int dl = 0;
        int dn = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done_l && dl == 0) dl = n;
            if (done_n && dn == 0) dn = n;
            if (dl != 0 && dn != 0) break;
        end
        total++; if (dl !== 11) begin bad++; $display("[TB] FAIL lat2_done_edge got=%0d want=11", dl); end
        total++; if (pass_l !== 1'b1) begin bad++; $display("[TB] FAIL lat2_pass got=%0h want=1", pass_l); end
        total++; if (err_l !== 16'h0) begin bad++; $display("[TB] FAIL lat2_err got=%0d want=0", err_l); end
        total++; if ({a_l, b_l} !== 4'hA) begin bad++; $display("[TB] FAIL lat2_last got=%0h want=a", {a_l, b_l}); end
        total++; if (dn !== 9) begin bad++; $display("[TB] FAIL lat0_done_edge got=%0d want=9", dn); end
        total++; if (err_n !== 16'd5) begin bad++; $display("[TB] FAIL lat0_err got=%0d want=5", err_n); end
        total++; if (pass_n !== 1'b0) begin bad++; $display("[TB] FAIL lat0_pass got=%0h want=0", pass_n); end
        total++; if ({fa_n, fb_n, fz_n} !== 6'b00_01_00) begin bad++; $display("[TB] FAIL lat0_first got=%0h want=4", {fa_n, fb_n, fz_n}); end
    endtask

    // Start ignored mid-RUN, reset at a=03 abandons the sweep, nothing restarts without start.
    task automatic test_reset_restart();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        total++; if ({busy_c, a_c, b_c} !== 17'h10000) begin bad++; $display("[TB] FAIL rr_first got=%0h want=10000", {busy_c, a_c, b_c}); end
        repeat (4) tick();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        total++; if ({a_c, b_c} !== 16'h0005) begin bad++; $display("[TB] FAIL rr_start_ignored got=%0h want=0005", {a_c, b_c}); end
        for (int n = 0; n < 2000; n++) begin
            if (a_c == 8'h03) break;
            tick();
        end
        total++; if ({a_c, b_c} !== 16'h0300) begin bad++; $display("[TB] FAIL rr_reach_a3 got=%0h want=0300", {a_c, b_c}); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if ({busy_c, done_c, a_c} !== 10'h0) begin bad++; $display("[TB] FAIL rr_abandon got=%0h want=0", {busy_c, done_c, a_c}); end
        tick();
        rst = 1'b0;
        repeat (2) tick();
        total++; if ({busy_c, done_c} !== 2'b00) begin bad++; $display("[TB] FAIL rr_idle got=%0h want=0", {busy_c, done_c}); end
    endtask

    // Full 65025-vector sweeps on the good array and the counting stuck-at array.
    task automatic test_full_sweep();
        int dc = 0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        total++; if ({busy_c, a_c, b_c} !== 17'h10000) begin bad++; $display("[TB] FAIL fs_restart got=%0h want=10000", {busy_c, a_c, b_c}); end
        for (int n = 1; n <= 66000; n++) begin
            tick();
            if (n == 9) begin
                total++; if ({done_s, pass_s, err_s} !== 18'h20001) begin bad++; $display("[TB] FAIL abort_state got=%0h want=20001", {done_s, pass_s, err_s}); end
                total++; if ({fa_s, fb_s, fz_s} !== 24'h000800) begin bad++; $display("[TB] FAIL abort_first got=%0h want=000800", {fa_s, fb_s, fz_s}); end
                total++; if ({a_s, b_s} !== 16'h0008) begin bad++; $display("[TB] FAIL abort_frozen got=%0h want=0008", {a_s, b_s}); end
            end
            if (n == 65024) begin
                total++; if ({busy_c, a_c, b_c} !== 17'h1FEFE) begin bad++; $display("[TB] FAIL fs_last_vec got=%0h want=1fefe", {busy_c, a_c, b_c}); end
            end
            if (done_c) begin
                dc = n;
                break;
            end
        end
        total++; if (dc !== 65025) begin bad++; $display("[TB] FAIL fs_done_edge got=%0d want=65025", dc); end
        total++; if ({pass_c, busy_c, err_c} !== 18'h20000) begin bad++; $display("[TB] FAIL fs_clean got=%0h want=20000", {pass_c, busy_c, err_c}); end
        total++; if ({a_c, b_c} !== 16'hFEFE) begin bad++; $display("[TB] FAIL fs_frozen got=%0h want=fefe", {a_c, b_c}); end
        total++; if ({done_f, pass_f} !== 2'b10) begin bad++; $display("[TB] FAIL full_flags got=%0h want=2", {done_f, pass_f}); end
        total++; if (err_f !== 16'd48641) begin bad++; $display("[TB] FAIL full_err got=%0d want=48641", err_f); end
        total++; if ({fa_f, fb_f, fz_f} !== 24'h000800) begin bad++; $display("[TB] FAIL full_first got=%0h want=000800", {fa_f, fb_f, fz_f}); end
    endtask

    // Start from DONE reruns with the error record cleared.
    task automatic test_done_rerun();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        total++; if ({busy_s, done_s, pass_s, err_s} !== 19'h40000) begin bad++; $display("[TB] FAIL rerun_clear got=%0h want=40000", {busy_s, done_s, pass_s, err_s}); end
        total++; if ({fa_s, fb_s, fz_s, a_s, b_s} !== 40'h0) begin bad++; $display("[TB] FAIL rerun_vec got=%0h want=0", {fa_s, fb_s, fz_s, a_s, b_s}); end
        total++; if ({busy_c, done_c, err_c} !== 18'h20000) begin bad++; $display("[TB] FAIL rerun_clean got=%0h want=20000", {busy_c, done_c, err_c}); end
        repeat (9) tick();
        total++; if ({done_s, err_s, fb_s} !== 25'h1000108) begin bad++; $display("[TB] FAIL rerun_abort got=%0h want=1000108", {done_s, err_s, fb_s}); end
    endtask

    initial begin
        rst    = 1'b1;
        start8 = 1'b0;
        start2 = 1'b0;
        test_reset();
        test_latency();
        test_reset_restart();
        test_full_sweep();
        test_done_rerun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
